result_writeback_pipe: RTL and testbench

- Consumes execute-stage results (ALU result, destination RT, register-write flag, op latency) and holds them in flight for a per-op latency of 1..MAX_LAT cycles.
- Drives the single 128-bit register-file write port.
- Supplies forwarding hits and data for the RA/RB/RC read addresses of the instruction entering execute.
- Guarantees one writeback per cycle and correct write-after-write (WAW) ordering.

---
 rtl/result_writeback_pipe.sv | 172 +++++++++++++++++
 tb/tb_result_writeback_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_pipe.sv
// Result writeback pipe: holds execute results for their op latency, drives the single
// register-file write port and forwards in-flight values to the three read ports.
module result_writeback_pipe #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7,
  parameter int MAX_LAT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [2:0]        ex_latency,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic              ex_reg_write,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_ra_addr,
  input  logic [ADDR_W-1:0] rd_rb_addr,
  input  logic [ADDR_W-1:0] rd_rc_addr,
  output logic              fwd_ra_hit,
  output logic              fwd_rb_hit,
  output logic              fwd_rc_hit,
  output logic [DATA_W-1:0] fwd_ra_data,
  output logic [DATA_W-1:0] fwd_rb_data,
  output logic [DATA_W-1:0] fwd_rc_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  localparam int NSLOT = MAX_LAT;
  localparam int AGE_W = $clog2(MAX_LAT + 1);

  // Entries live in the slot indexed by their remaining cycles, so the table shifts
  // down one slot per edge and slot 0 is always the retiring entry. Accept blocking
  // guarantees at most one entry per rem value.
  logic [NSLOT-1:0]  valid_q, valid_d;
  logic [NSLOT-1:0]  we_q, we_d;
  logic [ADDR_W-1:0] rt_q   [NSLOT];
  logic [ADDR_W-1:0] rt_d   [NSLOT];
  logic [DATA_W-1:0] data_q [NSLOT];
  logic [DATA_W-1:0] data_d [NSLOT];
  logic [AGE_W-1:0]  age_q  [NSLOT];
  logic [AGE_W-1:0]  age_d  [NSLOT];

  logic [2:0]        lat_s;
  logic              accept_s;
  logic [ADDR_W-1:0] rd_addr_s [3];
  logic              hit_s     [3];
  logic [DATA_W-1:0] fdata_s   [3];
  logic [AGE_W-1:0]  best_s    [3];

  always_comb begin
    lat_s = ex_latency;
    if (ex_latency == 3'd0) begin
      lat_s = 3'd1;
    end else if (int'(ex_latency) > MAX_LAT) begin
      lat_s = 3'(MAX_LAT);
    end else begin
      lat_s = ex_latency;
    end
  end

  always_comb begin
    ex_ready = 1'b1;
    for (int r = 0; r < NSLOT; r++) begin
      if (valid_q[r] && (r == int'(lat_s))) begin
        ex_ready = 1'b0;
      end else begin
        ex_ready = ex_ready;
      end
    end
  end

  assign accept_s = ex_valid && ex_ready && !flush;

  always_comb begin
    valid_d = '0;
    we_d    = '0;
    for (int r = 0; r < NSLOT; r++) begin
      rt_d[r]   = '0;
      data_d[r] = '0;
      age_d[r]  = '0;
    end
    for (int r = 0; r < NSLOT - 1; r++) begin
      valid_d[r] = valid_q[r+1];
      we_d[r]    = we_q[r+1];
      rt_d[r]    = rt_q[r+1];
      data_d[r]  = data_q[r+1];
      age_d[r]   = age_q[r+1] + AGE_W'(1);
      // A younger write to the same register that retires earlier kills this one.
      if (accept_s && ex_reg_write && valid_q[r+1] && we_q[r+1] &&
          (rt_q[r+1] == ex_rt) && ((r + 1) > int'(lat_s))) begin
        we_d[r] = 1'b0;
      end else begin
        we_d[r] = we_q[r+1];
      end
    end
    if (accept_s) begin
      valid_d[int'(lat_s) - 1] = 1'b1;
      we_d[int'(lat_s) - 1]    = ex_reg_write;
      rt_d[int'(lat_s) - 1]    = ex_rt;
      data_d[int'(lat_s) - 1]  = ex_result;
      age_d[int'(lat_s) - 1]   = '0;
    end else begin
      valid_d = valid_d;
    end
    if (flush) begin
      valid_d = '0;
      we_d    = '0;
    end else begin
      valid_d = valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      we_q    <= '0;
      for (int r = 0; r < NSLOT; r++) begin
        rt_q[r]   <= '0;
        data_q[r] <= '0;
        age_q[r]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      for (int r = 0; r < NSLOT; r++) begin
        rt_q[r]   <= rt_d[r];
        data_q[r] <= data_d[r];
        age_q[r]  <= age_d[r];
      end
    end
  end

  assign rd_addr_s[0] = rd_ra_addr;
  assign rd_addr_s[1] = rd_rb_addr;
  assign rd_addr_s[2] = rd_rc_addr;

  // Youngest matching writer (smallest age) supplies the forwarded value.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      hit_s[p]   = 1'b0;
      fdata_s[p] = '0;
      best_s[p]  = '0;
      for (int r = 0; r < NSLOT; r++) begin
        if (valid_q[r] && we_q[r] && (rt_q[r] == rd_addr_s[p]) &&
            (!hit_s[p] || (age_q[r] < best_s[p]))) begin
          hit_s[p]   = 1'b1;
          fdata_s[p] = data_q[r];
          best_s[p]  = age_q[r];
        end else begin
          hit_s[p]   = hit_s[p];
        end
      end
    end
  end

  assign fwd_ra_hit  = hit_s[0];
  assign fwd_rb_hit  = hit_s[1];
  assign fwd_rc_hit  = hit_s[2];
  assign fwd_ra_data = fdata_s[0];
  assign fwd_rb_data = fdata_s[1];
  assign fwd_rc_data = fdata_s[2];

  assign wb_en   = valid_q[0] && we_q[0];
  assign wb_addr = wb_en ? rt_q[0] : '0;
  assign wb_data = wb_en ? data_q[0] : '0;
  assign busy    = |valid_q;

endmodule

// File: tb/tb_result_writeback_pipe.sv
// Directed-vector bench for result_writeback_pipe; cycle n is the interval after the
// n-th rising edge of a scenario, inputs driven at edge+1, outputs checked at edge+2.
module tb_result_writeback_pipe;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid;
  logic              ex_ready;
  logic [2:0]        ex_latency;
  logic [ADDR_W-1:0] ex_rt;
  logic              ex_reg_write;
  logic [DATA_W-1:0] ex_result;
  logic              flush;
  logic [ADDR_W-1:0] rd_ra_addr, rd_rb_addr, rd_rc_addr;
  logic              fwd_ra_hit, fwd_rb_hit, fwd_rc_hit;
  logic [DATA_W-1:0] fwd_ra_data, fwd_rb_data, fwd_rc_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  result_writeback_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_LAT(7)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_latency(ex_latency), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write),
    .ex_result(ex_result), .flush(flush),
    .rd_ra_addr(rd_ra_addr), .rd_rb_addr(rd_rb_addr), .rd_rc_addr(rd_rc_addr),
    .fwd_ra_hit(fwd_ra_hit), .fwd_rb_hit(fwd_rb_hit), .fwd_rc_hit(fwd_rc_hit),
    .fwd_ra_data(fwd_ra_data), .fwd_rb_data(fwd_rb_data), .fwd_rc_data(fwd_rc_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    ex_latency   = 3'd1;
    ex_rt        = 7'd0;
    ex_reg_write = 1'b0;
    ex_result    = '0;
    flush        = 1'b0;
  endtask

  task automatic present(input logic [2:0] lat, input logic [ADDR_W-1:0] rt,
                         input logic we, input logic [DATA_W-1:0] d);
    ex_valid     = 1'b1;
    ex_latency   = lat;
    ex_rt        = rt;
    ex_reg_write = we;
    ex_result    = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd_ra_addr = 7'd0;
    rd_rb_addr = 7'd0;
    rd_rc_addr = 7'd0;
    tick();
    tick();
    #1;
    check_eq("rst_wb_en", wb_en, 0);
    check_eq("rst_wb_addr", wb_addr, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_ready", ex_ready, 1);
    reset = 1'b0;

    // Idle after reset
    repeat (5) tick();
    #1;
    check_eq("idle_ready", ex_ready, 1);
    check_eq("idle_wb_en", wb_en, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_hits", {fwd_ra_hit, fwd_rb_hit, fwd_rc_hit}, 0);
    check_eq("idle_fdata", fwd_ra_data, 0);

    // Latency-1 op with forwarding in its retire cycle
    tick(); present(3'd1, 7'd5, 1'b1, 128'hA5A5); #1;
    check_eq("l1_ready", ex_ready, 1);
    tick(); idle(); rd_ra_addr = 7'd5; #1;
    check_eq("l1_wb_en", wb_en, 1);
    check_eq("l1_wb_addr", wb_addr, 5);
    check_eq("l1_wb_data", wb_data, 128'hA5A5);
    check_eq("l1_fwd_hit", fwd_ra_hit, 1);
    check_eq("l1_fwd_data", fwd_ra_data, 128'hA5A5);
    tick(); #1;
    check_eq("l1_busy_clr", busy, 0);
    check_eq("l1_wb_clr", wb_en, 0);
    check_eq("l1_fwd_clr", fwd_ra_hit, 0);

    // Structural hazard; latency 0 treated as 1
    tick(); present(3'd3, 7'd10, 1'b1, 128'h1010); #1;
    tick(); ex_valid = 1'b0; ex_latency = 3'd2; rd_rb_addr = 7'd10; #1;
    check_eq("sh_ready_novalid", ex_ready, 0);
    present(3'd2, 7'd20, 1'b1, 128'h2020); #1;
    check_eq("sh_ready_lat2", ex_ready, 0);
    present(3'd0, 7'd20, 1'b1, 128'h2020); #1;
    check_eq("sh_ready_lat0", ex_ready, 1);
    check_eq("sh_fwd_hit", fwd_rb_hit, 1);
    check_eq("sh_fwd_data", fwd_rb_data, 128'h1010);
    tick(); idle(); #1;
    check_eq("sh_wb2_en", wb_en, 1);
    check_eq("sh_wb2_addr", wb_addr, 20);
    check_eq("sh_wb2_data", wb_data, 128'h2020);
    tick(); #1;
    check_eq("sh_wb3_addr", wb_addr, 10);
    check_eq("sh_wb3_data", wb_data, 128'h1010);
    tick(); #1;
    check_eq("sh_busy_clr", busy, 0);

    // WAW kill and youngest-wins forwarding
    tick(); present(3'd6, 7'd7, 1'b1, 128'h11); rd_rc_addr = 7'd7; #1;
    check_eq("waw_no_self_fwd", fwd_rc_hit, 0);
    tick(); present(3'd2, 7'd7, 1'b1, 128'h22); #1;
    check_eq("waw_fwd_c1", fwd_rc_data, 128'h11);
    tick(); idle(); #1;
    check_eq("waw_fwd_c2", fwd_rc_data, 128'h22);
    check_eq("waw_wb_c2", wb_en, 0);
    tick(); #1;
    check_eq("waw_wb_en_c3", wb_en, 1);
    check_eq("waw_wb_addr_c3", wb_addr, 7);
    check_eq("waw_wb_data_c3", wb_data, 128'h22);
    check_eq("waw_fwd_c3", fwd_rc_data, 128'h22);
    tick(); #1;
    check_eq("waw_fwd_hit_c4", fwd_rc_hit, 0);
    check_eq("waw_busy_c4", busy, 1);
    tick(); tick(); #1;
    check_eq("waw_wb_c6", wb_en, 0);
    check_eq("waw_busy_c6", busy, 1);
    tick(); #1;
    check_eq("waw_busy_c7", busy, 0);

    // Flush with entries at rem 0/2/4 and a new op presented
    tick(); present(3'd3, 7'd1, 1'b1, 128'h31);
    tick(); present(3'd4, 7'd2, 1'b1, 128'h32);
    tick(); present(3'd5, 7'd3, 1'b1, 128'h33);
    tick(); present(3'd1, 7'd4, 1'b1, 128'h34); flush = 1'b1; #1;
    check_eq("fl_wb_en", wb_en, 1);
    check_eq("fl_wb_addr", wb_addr, 1);
    check_eq("fl_wb_data", wb_data, 128'h31);
    check_eq("fl_ready", ex_ready, 1);
    tick(); idle(); #1;
    check_eq("fl_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      check_eq("fl_no_wb", wb_en, 0);
      tick();
    end

    // Reset mid-flight
    present(3'd2, 7'd11, 1'b1, 128'h41);
    tick(); present(3'd4, 7'd12, 1'b1, 128'h42);
    tick(); present(3'd6, 7'd13, 1'b1, 128'h43);
    tick(); idle(); reset = 1'b1; #1;
    check_eq("rs_busy_pre", busy, 1);
    tick(); reset = 1'b0; #1;
    check_eq("rs_wb_en", wb_en, 0);
    check_eq("rs_busy", busy, 0);
    check_eq("rs_ready", ex_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq("rs_no_wb", wb_en, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
